// File: rtl/la_oa_pipe_pkg.sv
// Shared constants and the per-lane Or-And / And-Or evaluation function for la_oa_pipe.
// Optional build macro: LA_OA_PIPE_PERF_EN (adds the stall counter in the top).
package la_oa_pipe_pkg;

    localparam string MODE_OA = "OA";
    localparam string MODE_AO = "AO";
    localparam int    COUNT_W = 32;
    localparam int    MAX_N   = 64;

    typedef enum logic {
        LANE_OA = 1'b0,
        LANE_AO = 1'b1
    } lane_mode_e;

    // Callers pad unused a_lane bits with the reduction's identity: 0 for OA, 1 for AO.
    function automatic logic lane_eval(
        input lane_mode_e       mode,
        input logic [MAX_N-1:0] a_lane,
        input logic             b_lane
    );
        if (mode == LANE_AO) begin
            return (&a_lane) | b_lane;
        end
        return (|a_lane) & b_lane;
    endfunction

endpackage

// File: rtl/la_oa_pipe_stage.sv
// One valid/ready pipeline register stage; an empty stage accepts even while downstream stalls.
// Optional build macro: LA_OA_PIPE_PERF_EN (not used in this file).
module la_oa_pipe_stage
    import la_oa_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         i_up_valid,
    output logic         o_up_ready,
    input  logic [W-1:0] i_up_data,
    output logic         o_dn_valid,
    input  logic         i_dn_ready,
    output logic [W-1:0] o_dn_data
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_load;

    assign o_up_ready = !r_valid || i_dn_ready;
    assign w_load     = i_up_valid && o_up_ready;

    // NOTE: non-blocking assignments keep every stage sampling pre-edge values, so beats advance one stage per edge.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_valid <= 1'b0;
            // NOTE: the data register is reset too, so z reads 0 (not stale data) while out_valid is low after reset.
            r_data  <= '0;
        end else begin
            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= i_up_data;
            end else if (i_dn_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_dn_valid = r_valid;
    assign o_dn_data  = r_data;

endmodule

// File: rtl/la_oa_pipe.sv
// Multi-lane Or-And (MODE "OA") / And-Or (MODE "AO") array registered through STAGES valid/ready stages.
// Optional build macro: LA_OA_PIPE_PERF_EN adds the saturating stall_count output.
module la_oa_pipe
    import la_oa_pipe_pkg::*;
#(
    parameter int    WIDTH  = 8,
    parameter int    N      = 2,
    parameter int    STAGES = 2,
    parameter string MODE   = "OA",
    parameter string PROP   = "DEFAULT"
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH*N-1:0] a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   z
`ifdef LA_OA_PIPE_PERF_EN
    ,
    output logic [COUNT_W-1:0] stall_count
`endif
);

    localparam lane_mode_e LP_MODE = (MODE == MODE_AO) ? LANE_AO : LANE_OA;

    if ((MODE != MODE_OA) && (MODE != MODE_AO)) begin : g_bad_mode
        $error("la_oa_pipe: MODE must be \"OA\" or \"AO\"");
    end
    if ((WIDTH < 1) || (N < 1) || (N > MAX_N) || (STAGES < 1)) begin : g_bad_size
        $error("la_oa_pipe: WIDTH, N, STAGES must be >= 1 and N <= MAX_N");
    end
    if (PROP == "") begin : g_bad_prop
        $error("la_oa_pipe: PROP must not be empty");
    end

    // Only the WIDTH-bit results are registered, never the WIDTH*N operand bits.
    logic [WIDTH-1:0] w_lane_z;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic [MAX_N-1:0] w_a_lane;

        // NOTE: w_a_lane gets a full default before the partial overwrite, so no latch is inferred.
        always_comb begin
            w_a_lane        = (LP_MODE == LANE_AO) ? '1 : '0;
            w_a_lane[N-1:0] = a[i*N +: N];
        end

        assign w_lane_z[i] = lane_eval(LP_MODE, w_a_lane, b[i]);
    end

    // Element k is the upstream side of stage k; element STAGES is the block output.
    logic             w_valid [STAGES+1];
    logic             w_ready [STAGES+1];
    logic [WIDTH-1:0] w_data  [STAGES+1];

    assign w_valid[0]      = in_valid;
    assign w_data[0]       = w_lane_z;
    assign w_ready[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        la_oa_pipe_stage #(
            .W (WIDTH)
        ) u_stage (
            .clk        (clk),
            .nreset     (nreset),
            .i_up_valid (w_valid[k]),
            .o_up_ready (w_ready[k]),
            .i_up_data  (w_data[k]),
            .o_dn_valid (w_valid[k+1]),
            .i_dn_ready (w_ready[k+1]),
            .o_dn_data  (w_data[k+1])
        );
    end

    assign in_ready  = w_ready[0];
    assign out_valid = w_valid[STAGES];
    assign z         = w_data[STAGES];

`ifdef LA_OA_PIPE_PERF_EN
    logic [COUNT_W-1:0] r_stall_count;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_stall_count <= '0;
        end else if (out_valid && !out_ready && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + COUNT_W'(1);
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule
